// File: rtl/sc_pointtype_seq_pkg.sv
// Shared encodings for the point-type register sequencer: FSM states,
// shift-select codes and rotate direction.
package sc_pointtype_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD0 = 3'd2,
    RUN   = 3'd3,
    SHIFT = 3'd4,
    LOAD1 = 3'd5,
    TRANS = 3'd6,
    PAUSE = 3'd7
  } state_t;

  localparam logic [1:0] SHIFT_NONE  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  function automatic logic [1:0] shiftCode(input logic dir);
    return (dir == RIGHT) ? SHIFT_RIGHT : SHIFT_LEFT;
  endfunction

endpackage

// File: rtl/sc_pointtype_prescaler.sv
// Free-running divider producing a one-cycle shift tick every TICK_PERIOD
// enabled cycles; holds its count while disabled.
module sc_pointtype_prescaler #(
  parameter int TICK_PERIOD = 25000000,
  parameter int TICK_WIDTH  = 25
) (
  input  logic SC_RegPOINTTYPE_CLOCK_50,
  input  logic SC_RegPOINTTYPE_RESET_InHigh,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam logic [TICK_WIDTH-1:0] LAST = TICK_WIDTH'(TICK_PERIOD - 1);

  logic [TICK_WIDTH-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
    if (SC_RegPOINTTYPE_RESET_InHigh) count <= '0;
    else if (restart)                 count <= '0;
    else if (enable)                  count <= tick ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/sc_pointtype_sequencer.sv
// Control FSM for the point-type register: clear, load0, periodic rotate,
// level-advance load1 and transition patterns. Define SC_POINTTYPE_SEQ_PAUSE_EN for pause.
module sc_pointtype_sequencer
  import sc_pointtype_seq_pkg::*;
#(
  parameter int DATAWIDTH        = 8,
  parameter int TICK_PERIOD      = 25000000,
  parameter int TICK_WIDTH       = 25,
  parameter int SHIFTS_PER_LEVEL = 8,
  parameter int LEVEL_WIDTH      = 3,
  parameter logic [DATAWIDTH-1:0] TRANS_PATTERN = 8'b10000001
) (
  input  logic                   SC_RegPOINTTYPE_CLOCK_50,
  input  logic                   SC_RegPOINTTYPE_RESET_InHigh,
  input  logic                   start_InLow,
  input  logic                   stop_InLow,
  input  logic                   left_InLow,
  input  logic                   right_InLow,
  input  logic                   levelup_InLow,
  input  logic                   pause_InLow,
  output logic                   clear_OutLow,
  output logic                   load0_OutLow,
  output logic                   load1_OutLow,
  output logic [1:0]             shiftselection_Out,
  output logic                   transition_Out,
  output logic [DATAWIDTH-1:0]   transitionDATA_OutBUS,
  output logic [LEVEL_WIDTH-1:0] level_OutBUS,
  busy_Out
);

  localparam int SCW = $clog2(SHIFTS_PER_LEVEL + 1);
  localparam logic [SCW-1:0] SHIFT_LAST = SCW'(SHIFTS_PER_LEVEL - 1);

  state_t                 state, nextState;
  logic                   dir, nextDir;
  logic [LEVEL_WIDTH-1:0] level, nextLevel;
  logic [SCW-1:0]         shiftCnt, nextShiftCnt;
  logic                   tick, stopReq, pauseEdge, prescEnable, prescRestart;
  logic [2*DATAWIDTH-1:0] patPair;
  logic [DATAWIDTH-1:0]   transPat;

`ifdef SC_POINTTYPE_SEQ_PAUSE_EN
  logic pausePrev;
  always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
    if (SC_RegPOINTTYPE_RESET_InHigh) pausePrev <= 1'b1;
    else                              pausePrev <= pause_InLow;
  end
  assign pauseEdge = pausePrev && !pause_InLow;
`else
  logic unusedPause;
  assign unusedPause = pause_InLow;
  assign pauseEdge   = 1'b0;
`endif

  assign stopReq      = (state != IDLE) && !stop_InLow;
  // Freeze the count on the pause edge so a paused run resumes mid-period.
  assign prescEnable  = (state == RUN) && !pauseEdge;
  assign prescRestart = stopReq || (state inside {IDLE, CLEAR, TRANS});

  sc_pointtype_prescaler #(
    .TICK_PERIOD (TICK_PERIOD),
    .TICK_WIDTH  (TICK_WIDTH)
  ) uPrescaler (
    .SC_RegPOINTTYPE_CLOCK_50     (SC_RegPOINTTYPE_CLOCK_50),
    .SC_RegPOINTTYPE_RESET_InHigh (SC_RegPOINTTYPE_RESET_InHigh),
    .enable                       (prescEnable),
    .restart                      (prescRestart),
    .tick                         (tick)
  );

  always_comb begin
    nextState    = state;
    nextDir      = dir;
    nextLevel    = level;
    nextShiftCnt = shiftCnt;
    if (state != IDLE) begin
      if (!left_InLow && right_InLow)      nextDir = LEFT;
      else if (left_InLow && !right_InLow) nextDir = RIGHT;
    end
    if (stopReq) begin
      nextState    = IDLE;
      nextShiftCnt = '0;
    end else begin
      case (state)
        IDLE:  if (!start_InLow) nextState = CLEAR;
        CLEAR: begin
          nextState    = LOAD0;
          nextLevel    = '0;
          nextShiftCnt = '0;
          nextDir      = LEFT;
        end
        LOAD0: nextState = RUN;
        RUN: begin
          // levelup wins over a coincident tick; that tick is dropped.
          if (!levelup_InLow) nextState = TRANS;
          else if (pauseEdge) nextState = PAUSE;
          else if (tick)      nextState = SHIFT;
        end
        SHIFT: begin
          if (shiftCnt == SHIFT_LAST) begin
            nextShiftCnt = '0;
            nextState    = LOAD1;
          end else begin
            nextShiftCnt = shiftCnt + 1'b1;
            nextState    = RUN;
          end
        end
        LOAD1: begin
          nextLevel = level + 1'b1;
          nextState = RUN;
        end
        TRANS: nextState = RUN;
`ifdef SC_POINTTYPE_SEQ_PAUSE_EN
        PAUSE: if (pauseEdge) nextState = RUN;
`endif
        default: nextState = IDLE;
      endcase
    end
  end

  // Upper half of the doubled pattern shifted left is the rotate-left result.
  assign patPair  = {TRANS_PATTERN, TRANS_PATTERN} << (int'(nextLevel) % DATAWIDTH);
  assign transPat = patPair[2*DATAWIDTH-1 -: DATAWIDTH];

  always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
    if (SC_RegPOINTTYPE_RESET_InHigh) begin
      state                 <= IDLE;
      dir                   <= LEFT;
      level                 <= '0;
      shiftCnt              <= '0;
      clear_OutLow          <= 1'b1;
      load0_OutLow          <= 1'b1;
      load1_OutLow          <= 1'b1;
      shiftselection_Out    <= SHIFT_NONE;
      transition_Out        <= 1'b0;
      transitionDATA_OutBUS <= '0;
      busy_Out              <= 1'b0;
    end else begin
      state                 <= nextState;
      dir                   <= nextDir;
      level                 <= nextLevel;
      shiftCnt              <= nextShiftCnt;
      clear_OutLow          <= (nextState != CLEAR);
      load0_OutLow          <= (nextState != LOAD0);
      load1_OutLow          <= (nextState != LOAD1);
      shiftselection_Out    <= (nextState == SHIFT) ? shiftCode(nextDir) : SHIFT_NONE;
      transition_Out        <= (nextState == TRANS);
      transitionDATA_OutBUS <= (nextState == TRANS) ? transPat : '0;
      busy_Out              <= (nextState != IDLE);
    end
  end

  assign level_OutBUS = level;

endmodule

// File: tb/tb_sc_pointtype_sequencer.sv
// Scoreboard bench for sc_pointtype_sequencer: stimulus queues expected command
// events (kind, data, level, spacing); a monitor pops them as the DUT issues commands.
module tb_sc_pointtype_sequencer;

  logic       clk = 1'b0, rst = 1'b1;
  logic       startN = 1'b1, stopN = 1'b1, leftN = 1'b1, rightN = 1'b1;
  logic       levelupN = 1'b1, pauseN = 1'b1;
  logic       clearN, load0N, load1N, trn, busy;
  logic [1:0] shsel;
  logic [7:0] tdata;
  logic [2:0] level;

  sc_pointtype_sequencer #(
    .DATAWIDTH(8), .TICK_PERIOD(4), .TICK_WIDTH(3), .SHIFTS_PER_LEVEL(3),
    .LEVEL_WIDTH(3), .TRANS_PATTERN(8'b10000001)
  ) dut (
    .SC_RegPOINTTYPE_CLOCK_50(clk), .SC_RegPOINTTYPE_RESET_InHigh(rst),
    .start_InLow(startN), .stop_InLow(stopN), .left_InLow(leftN), .right_InLow(rightN),
    .levelup_InLow(levelupN), .pause_InLow(pauseN),
    .clear_OutLow(clearN), .load0_OutLow(load0N), .load1_OutLow(load1N),
    .shiftselection_Out(shsel), .transition_Out(trn), .transitionDATA_OutBUS(tdata),
    .level_OutBUS(level), .busy_Out(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0] cmd;   // {clear, load0, load1, shsel[1:0], transition}, active-high
    logic [7:0] data;
    logic [2:0] lvl;
    int         gap;   // cycles since previous command, <0 = unchecked
  } evt_t;

  localparam logic [5:0] C_CLR = 6'b100000, C_LD0 = 6'b010000, C_LD1 = 6'b001000;
  localparam logic [5:0] C_SHL = 6'b000010, C_SHR = 6'b000100, C_TRN = 6'b000001;

  evt_t expQ[$];
  int   nChecks = 0, nPass = 0;

  task automatic push(input logic [5:0] cmd, input logic [7:0] data, input int lvl, input int gap);
    evt_t e;
    e.cmd = cmd; e.data = data; e.lvl = 3'(lvl); e.gap = gap;
    expQ.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic waitDrain(input int bound);
    int n;
    n = 0;
    do begin @(posedge clk); #2; n++; end while (expQ.size() != 0 && n < bound);
    if (expQ.size() != 0) begin
      nChecks++;
      $display("FAIL drain: %0d events outstanding after %0d cycles", expQ.size(), n);
      expQ.delete();
    end
  endtask

  task automatic monitorLoop();
    logic [5:0] act;
    evt_t       e;
    int         lastEvt, gap;
    lastEvt = 0;
    forever begin
      @(negedge clk);
      act = {~clearN, ~load0N, ~load1N, shsel, trn};
      if (!rst && act != 6'b0) begin
        nChecks++;
        gap = cyc - lastEvt;
        if (expQ.size() == 0) begin
          $display("FAIL event: unexpected cmd=%b lvl=%0d at cycle %0d", act, level, cyc);
        end else begin
          e = expQ.pop_front();
          if (act === e.cmd && tdata === e.data && level === e.lvl && (e.gap < 0 || gap == e.gap))
            nPass++;
          else
            $display("FAIL event: got cmd=%b data=%b lvl=%0d gap=%0d, expected cmd=%b data=%b lvl=%0d gap=%0d",
                     act, tdata, level, gap, e.cmd, e.data, e.lvl, e.gap);
        end
        lastEvt = cyc;
      end
    end
  endtask

  task automatic pushLevel(input logic [5:0] sh, input int lvl);
    repeat (3) push(sh, 8'h00, lvl, 5);
    push(C_LD1, 8'h00, lvl, 1);
  endtask

  initial begin
    fork monitorLoop(); join_none

    // Reset state
    step(2);
    check("reset busy", busy, 0);
    check("reset clear", clearN, 1);
    check("reset shsel", shsel, 0);
    check("reset level", level, 0);
    check("reset tdata", tdata, 0);
    rst = 1'b0;
    step(1);

    // Start, rotate left through all levels until the level counter wraps
    push(C_CLR, 8'h00, 0, -1);
    push(C_LD0, 8'h00, 0, 1);
    for (int l = 0; l < 8; l++) pushLevel(C_SHL, l);
    startN = 1'b0; step(1); startN = 1'b1;
    waitDrain(300);
    check("level wrap", level, 0);

    // Right press switches direction, held after release
    rightN = 1'b0;
    pushLevel(C_SHR, 0);
    pushLevel(C_SHR, 1);
    step(1); rightN = 1'b1;
    waitDrain(100);

    // levelup at level 2 on the tick cycle: tick dropped, prescaler restarts
    step(3);
    levelupN = 1'b0;
    push(C_TRN, 8'b00000110, 2, 5);
    push(C_SHR, 8'h00, 2, 5);
    push(C_SHR, 8'h00, 2, 5);
    step(1); levelupN = 1'b1;
    step(10);
    stopN = 1'b0;            // DUT is in SHIFT here
    step(1); stopN = 1'b1;
    check("stop busy", busy, 0);
    check("stop level kept", level, 2);
    check("stop shsel", shsel, 0);

    // Restart from IDLE: level cleared, direction back to left
    push(C_CLR, 8'h00, 2, -1);
    push(C_LD0, 8'h00, 0, 1);
    pushLevel(C_SHL, 0);
    startN = 1'b0; step(1); startN = 1'b1;
    waitDrain(100);
    check("level after reload", level, 1);

    // Asynchronous reset while a shift command is on the outputs
    step(4);
    rst = 1'b1;
    #1;
    check("async busy", busy, 0);
    check("async shsel", shsel, 0);
    check("async level", level, 0);
    check("async load1", load1N, 1);
    step(1);
    rst = 1'b0;
    push(C_CLR, 8'h00, 0, -1);
    push(C_LD0, 8'h00, 0, 1);
    push(C_SHL, 8'h00, 0, 5);
    startN = 1'b0; step(1); startN = 1'b1;
    waitDrain(50);

`ifdef SC_POINTTYPE_SEQ_PAUSE_EN
    // Pause at prescaler count 1, hold 20 cycles, resume the remaining count
    step(1);
    pauseN = 1'b0;
    push(C_SHL, 8'h00, 0, 27);
    step(1); pauseN = 1'b1;
    step(20);
    pauseN = 1'b0;
    step(1); pauseN = 1'b1;
    waitDrain(50);
`endif

    check("queue empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/sc_pointtype_sequencer.md
Name: sc_pointtype_sequencer

Overview:
- Control FSM that sequences the point-type register: clear, initial load, periodic rotate (left/right), level-advance load and one-shot transition patterns.
- Sits between the board buttons/game logic and the point-type register. Drives that register's clear, load0, load1, shiftselection, transition and transitionDATA inputs.
- Contains an internal prescaler that produces the periodic shift tick from the 50 MHz clock.

Parameters:
- DATAWIDTH, 8, width of the controlled register and of transitionDATA.
- TICK_PERIOD, 25000000, clock cycles between shift ticks; must be >= 2.
- TICK_WIDTH, 25, prescaler counter width; must satisfy 2^TICK_WIDTH >= TICK_PERIOD.
- SHIFTS_PER_LEVEL, 8, shifts completed before a level-advance load1.
- LEVEL_WIDTH, 3, width of the level counter.
- TRANS_PATTERN, 8'b10000001, base pattern for transitions.

Ports:
- SC_RegPOINTTYPE_CLOCK_50  in  1  system clock.
- SC_RegPOINTTYPE_RESET_InHigh  in  1  reset.
- start_InLow  in  1  start request.
- stop_InLow  in  1  abort to IDLE.
- left_InLow  in  1  select rotate-left direction.
- right_InLow  in  1  select rotate-right direction.
- levelup_InLow  in  1  request a transition pattern.
- pause_InLow  in  1  pause toggle request (used only with the optional feature).
- clear_OutLow  out  1  clear command to the register.
- load0_OutLow  out  1  initial-load command.
- load1_OutLow  out  1  level-load command.
- shiftselection_Out  out  2  00 none, 01 rotate left, 10 rotate right.
- transition_Out  out  1  transition strobe.
- transitionDATA_OutBUS  out  DATAWIDTH  transition pattern.
- level_OutBUS  out  LEVEL_WIDTH  current level.
- busy_Out  out  1  high in every state except IDLE.

Behaviour:
- Reset SC_RegPOINTTYPE_RESET_InHigh: asynchronous, active-high. Clock SC_RegPOINTTYPE_CLOCK_50.
- Reset values:
  - state = IDLE, dir = LEFT, level = 0, shift count = 0, prescaler = 0.
  - clear/load0/load1 = 1, shiftselection = 00, transition = 0, transitionDATA = 0, busy = 0.
- Command outputs are a Moore decode of the state register. A command is visible during the cycle the state is entered, so the register acts on it at the next edge.
- States:
  - IDLE: all commands inactive. start_InLow==0 → CLEAR.
  - CLEAR: clear_OutLow=0 for 1 cycle. Sets level=0, shift count=0, dir=LEFT. → LOAD0.
  - LOAD0: load0_OutLow=0 for 1 cycle. → RUN.
  - RUN:
    - Prescaler counts 0..TICK_PERIOD-1; the tick fires on the cycle the count equals TICK_PERIOD-1, then the count wraps to 0.
    - levelup_InLow==0 → TRANS.
    - Otherwise, on tick → SHIFT.
  - SHIFT: shiftselection=01 if dir=LEFT, 10 if RIGHT, for 1 cycle. Shift count is incremented.
    - If the count reaches SHIFTS_PER_LEVEL, reset it to 0 → LOAD1.
    - Otherwise → RUN.
  - LOAD1: load1_OutLow=0 for 1 cycle. level incremented (wraps modulo 2^LEVEL_WIDTH). → RUN.
  - TRANS: transition_Out=1 for 1 cycle, transitionDATA = TRANS_PATTERN rotated left by level. Prescaler restarts at 0. → RUN.
  - PAUSE: exists only with the optional feature.
- Direction: sampled every non-IDLE cycle.
  - left low alone → LEFT; right low alone → RIGHT.
  - Both low or both high → hold.
- Priorities:
  - Reset > stop_InLow==0 (any non-IDLE state → IDLE next edge, all counters except level cleared) > levelup > tick.
  - A tick coinciding with levelup is discarded.
- transitionDATA_OutBUS is 0 outside TRANS.
- Inputs are assumed synchronous, level-sensitive. levelup held low re-enters TRANS every other cycle; the bench holds it 1 cycle.

Optional Feature:
- SC_POINTTYPE_SEQ_PAUSE_EN defined:
  - In RUN, a falling edge of pause_InLow → PAUSE (prescaler frozen, all commands inactive).
  - In PAUSE, the next falling edge → RUN, resuming the prescaler count.
  - stop_InLow still exits PAUSE to IDLE.
- Undefined: pause_InLow is ignored, no PAUSE state and no edge-detect flop.

Decomposition:
- Package sc_pointtype_seq_pkg:
  - state encoding constants: IDLE, CLEAR, LOAD0, RUN, SHIFT, LOAD1, TRANS, PAUSE (3 bits).
  - shift codes: SHIFT_NONE=2'b00, SHIFT_LEFT=2'b01, SHIFT_RIGHT=2'b10.
  - direction constants: LEFT=0, RIGHT=1.
- Sub-module sc_pointtype_prescaler:
  - inputs: enable, restart. Output: tick.
  - parameters: TICK_PERIOD, TICK_WIDTH.

Test Plan:
(Bench uses TICK_PERIOD=4, SHIFTS_PER_LEVEL=3.)
- Reset mid-RUN: assert reset asynchronously → same cycle busy=0, shiftselection=00, level=0; start → clear_OutLow low exactly 1 cycle, then load0_OutLow low 1 cycle.
- RUN with no buttons → shiftselection=01 pulse every 5 cycles (4 RUN + 1 SHIFT); right_InLow low → next pulse is 10.
- 3 shifts → load1_OutLow low 1 cycle, level_OutBUS 0→1; repeat to level 7 → next increment wraps to 0.
- levelup at level 2 → transition_Out=1 for 1 cycle with transitionDATA=8'b00000110; coincident tick dropped, next shift 5 cycles later.
- stop_InLow low during SHIFT → IDLE next edge, busy=0, level retained; start → CLEAR.
- With SC_POINTTYPE_SEQ_PAUSE_EN: pause press → no shifts for 20 cycles; second press → shift resumes after the remaining prescaler count.
